// File: rtl/fir_out_checker.sv
// Output scoreboard for the FIR datapath: golden samples are queued in a FIFO and
// compared bit-exact against filter outputs after a warm-up skip, with pass/fail stats.
module fir_out_checker #(
  parameter int OUT_WL   = 20,
  parameter int DATA_NUM = 500,
  parameter int SKIP     = 0,
  parameter int DEPTH    = 16,
  parameter int CNT_WL   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     gold_valid,
  input  logic signed [OUT_WL-1:0] gold_data,
  output logic                     gold_ready,
  input  logic                     dut_valid,
  input  logic signed [OUT_WL-1:0] dut_data,
  output logic                     busy,
  output logic                     mismatch,
  output logic [CNT_WL-1:0]        err_cnt,
  output logic [CNT_WL-1:0]        cmp_cnt,
  output logic [CNT_WL-1:0]        first_err_idx,
  output logic                     underflow,
  output logic                     done,
  output logic                     pass
);
  localparam int AW      = $clog2(DEPTH);
  localparam bit SKIP_EN = (SKIP > 0);

  typedef enum logic [1:0] {S_IDLE, S_SKIP, S_RUN, S_DONE} state_t;
  state_t state, state_nx;

  logic [OUT_WL-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic              full, empty, wr_en, rd_en;
  logic              go, cmp_ev, cmp_fail, last_cmp, skip_last;
  logic [CNT_WL-1:0] skip_cnt, skip_inc, cmp_inc, err_inc, err_nx;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_comb begin
    empty      = (wr_ptr == rd_ptr);
    full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    gold_ready = !full;
    busy       = (state == S_SKIP) || (state == S_RUN);
    wr_en      = gold_valid && !full;
    go         = start && ((state == S_IDLE) || (state == S_DONE));
    cmp_ev     = (state == S_RUN) && dut_valid;
    rd_en      = cmp_ev && !empty;
    // An empty FIFO is a failed comparison; same-cycle writes are never bypassed.
    cmp_fail   = cmp_ev && (empty || (mem[rd_ptr[AW-1:0]] != dut_data));
    cmp_inc    = cmp_cnt + 1'b1;
    skip_inc   = skip_cnt + 1'b1;
    err_inc    = (err_cnt == '1) ? err_cnt : err_cnt + 1'b1;
    err_nx     = cmp_fail ? err_inc : err_cnt;
    last_cmp   = cmp_ev && (cmp_inc == CNT_WL'(DATA_NUM));
    skip_last  = (state == S_SKIP) && dut_valid && (skip_inc == CNT_WL'(SKIP));
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nx = SKIP_EN ? S_SKIP : S_RUN;
      S_SKIP:         if (skip_last) state_nx = S_RUN;
      S_RUN:          if (last_cmp) state_nx = S_DONE;
      default:        state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= gold_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      skip_cnt      <= '0;
      cmp_cnt       <= '0;
      err_cnt       <= '0;
      first_err_idx <= '1;
      underflow     <= 1'b0;
      mismatch      <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
    end else begin
      state    <= state_nx;
      mismatch <= cmp_fail;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      if (go) begin
        skip_cnt      <= '0;
        cmp_cnt       <= '0;
        err_cnt       <= '0;
        first_err_idx <= '1;
        underflow     <= 1'b0;
        done          <= 1'b0;
        pass          <= 1'b0;
      end
      if ((state == S_SKIP) && dut_valid) skip_cnt <= skip_inc;
      if (cmp_ev) begin
        cmp_cnt <= cmp_inc;
        err_cnt <= err_nx;
        if (empty) underflow <= 1'b1;
        if (cmp_fail && (first_err_idx == '1)) first_err_idx <= cmp_cnt;
      end
      if (last_cmp) begin
        done <= 1'b1;
        pass <= (err_nx == '0) && !underflow && !empty;
      end
    end
  end
endmodule

// File: doc/fir_out_checker.md
# fir_out_checker

Synthesizable output scoreboard for the FIR filter datapath: the receiving end of the filter's output stream. It buffers expected (golden) samples in an internal FIFO and compares them one-for-one against filter output samples, after discarding a fixed number of pipeline warm-up outputs. It keeps mismatch statistics and raises a pass/fail verdict after a fixed sample count, so an FPGA build or a gate-level run can self-check with no file I/O.

## Interface
- OUT_WL, 20: signed width of filter output and golden samples.
- DATA_NUM, 500: number of compared samples per run (≥1).
- SKIP, 0: filter outputs discarded after start, before the first comparison.
- DEPTH, 16: golden FIFO depth, power of two, ≥2.
- CNT_WL, 16: width of all counters.

- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE.
- gold_valid  in  1  golden write request.
- gold_data  in  OUT_WL  signed golden sample.
- gold_ready  out  1  FIFO not full; a write occurs when gold_valid && gold_ready.
- dut_valid  in  1  filter output sample present this cycle.
- dut_data  in  OUT_WL  signed filter output sample.
- busy  out  1  state is SKIP or RUN.
- mismatch  out  1  one-cycle pulse per failed comparison.
- err_cnt  out  CNT_WL  failed comparisons, saturating.
- cmp_cnt  out  CNT_WL  comparisons done this run.
- first_err_idx  out  CNT_WL  0-based index of first failure; all-ones = none.
- underflow  out  1  sticky: sample arrived with FIFO empty.
- done  out  1  run complete (level, held).
- pass  out  1  valid when done: err_cnt==0 && !underflow.

## Operation
- States: IDLE, SKIP, RUN, DONE. Reset → IDLE.
- IDLE/DONE: start → SKIP if SKIP>0, else RUN. Clears err_cnt, cmp_cnt, skip counter, underflow, done, pass, mismatch; first_err_idx ← all-ones. FIFO contents are kept.
- start in SKIP/RUN: ignored.
- SKIP: each dut_valid increments skip counter, no FIFO pop. At the SKIP-th sample → RUN.
- RUN, dut_valid with FIFO non-empty: pop the head and compare it bit-exact with dut_data. Increment cmp_cnt. On inequality, pulse mismatch and increment err_cnt; if first_err_idx is all-ones, load the pre-increment cmp_cnt into it.
- RUN, dut_valid with FIFO empty: no pop. Set underflow. Counts as a failed comparison with the same counter/mismatch/first_err_idx updates.
- When the update makes cmp_cnt == DATA_NUM → DONE, done=1, pass computed.
- dut_valid in IDLE/DONE: ignored.
- FIFO: writes are accepted in every state. gold_ready = !full. When full, no write occurs, even if a pop happens the same cycle. A write into an empty FIFO is not bypassed to a same-cycle compare, so that case is underflow.
- err_cnt saturates at 2^CNT_WL-1.
- Reset value of every output: 0, except gold_ready=1 and first_err_idx=all-ones. rst mid-run flushes the FIFO and aborts the run.

## Timing
- Comparison is registered: dut_valid sampled at edge k. At edge k the following all update together: mismatch (high for the cycle after k), err_cnt, cmp_cnt, underflow, and the FIFO pointer.
- done/pass assert at the same edge as the final cmp_cnt update. Zero extra latency.
- Full-rate: one comparison per cycle sustained, given one golden write per cycle.
- gold_ready reflects registered occupancy and drops the cycle after the write that fills the FIFO.
- DONE holds outputs until start or rst.

## Test plan
- DEPTH=16, DATA_NUM=8, SKIP=0: preload 8 golden values {0,5,-3,100,-524288,524287,7,-1}, start, then drive identical dut_data on 8 consecutive cycles → mismatch never high, cmp_cnt=8, done=1, pass=1, err_cnt=0.
- Same setup, but dut index 3 is 101 instead of 100 → mismatch pulses the cycle after that sample. Final err_cnt=1, first_err_idx=3, pass=0.
- SKIP=2: start, then 2 garbage samples followed by the 8 matching samples → garbage is not compared, pass=1, cmp_cnt=8.
- Empty FIFO, start, one dut_valid → underflow=1, err_cnt=1, first_err_idx=0, cmp_cnt=1. A later preload and matching samples still end with pass=0.
- Write 17 values back-to-back with DEPTH=16 → gold_ready=0 after the 16th write. The 17th is not stored: after a full 16-sample matching run, a 17th comparison underflows.
- Assert rst mid-RUN after 4 comparisons → next cycle state IDLE, all outputs at reset values, FIFO empty (gold_ready=1). A fresh run passes.
